uart_receiver: RTL and testbench

//   Serial-to-parallel UART receiver, 8N1 format: 1 start, 8 data bits LSB first, 1 stop, no parity.

---
 rtl/uart_receiver.sv | 147 ++++++++++++++
 tb/tb_uart_receiver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   data_in        in   serial line, asynchronous to clk, idles high
//   byte_received  out  last correctly framed byte, held until the next good byte
//   byte_valid     out  one-cycle pulse when byte_received is updated
//   framing_error  out  one-cycle pulse when the stop bit is sampled low
//   busy           out  high whenever the receiver is not idle
module uart_receiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUDRATE = 57600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] byte_received,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUDRATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_STOP  = 5'b01000,
    S_BREAK = 5'b10000
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            ferr_q;
  logic            busy_q;

  // Two-flop synchronizer; resets to the idle (high) line level so no
  // false start bit is seen when reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= data_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= '0;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        // Re-check the start bit at its centre so short glitches are rejected.
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // LSB arrives first, so shifting right leaves D0 in bit 0.
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Returning to idle at mid-stop lets a following start edge be caught.
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A held-low line must go high before another start can be seen.
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_received = byte_q;
  assign byte_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUDRATE = 62_500;
  localparam int BIT      = CLK_FREQ / BAUDRATE;
  localparam int HALF     = BIT / 2;
  localparam int LATENCY  = 9 * BIT + HALF + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b1;
  logic [7:0] byte_received;
  logic       byte_valid;
  logic       framing_error;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int fe_cnt    = 0;
  int start_cyc = 0;
  bit busy_seen = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  int valid_cyc[$];

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .byte_received(byte_received),
    .byte_valid(byte_valid),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every frame sent with a good stop bit is queued and must
  // emerge in order; nothing else may produce a valid strobe.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (byte_valid) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("byte", byte_received, exp_q.pop_front());
      chk("busy_with_valid", busy, 0);
      chk("valid_fe_exclusive", framing_error, 0);
    end
    if (framing_error) fe_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      last_good = b;
    end
    start_cyc = cyc;
    data_in = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      wait_cyc(BIT);
    end
    data_in = stop_bit;
    wait_cyc(BIT);
  endtask

  initial begin
    int v0, f0, s0, bad;
    logic [7:0] r;

    // Reset state
    wait_cyc(3);
    chk("rst_byte", byte_received, 8'h00);
    chk("rst_valid", byte_valid, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    wait_cyc(20);

    // 1: single frame, exact latency from the start edge
    v0 = valid_cnt;
    send_byte(8'hA5, 1'b1);
    data_in = 1'b1;
    wait_cyc(2 * BIT);
    chk("t1_count", valid_cnt - v0, 1);
    chk("t1_byte", byte_received, 8'hA5);
    chk("t1_fe", fe_cnt, 0);
    if (valid_cyc.size() > 0) chk("t1_latency", valid_cyc[valid_cyc.size()-1] - start_cyc, LATENCY);
    else chk("t1_latency_missing", 0, 1);

    // 2: back-to-back frames, spaced one frame length apart
    v0 = valid_cnt;
    s0 = valid_cyc.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_cyc(2 * BIT);
    chk("t2_count", valid_cnt - v0, 3);
    if (valid_cyc.size() >= s0 + 3) begin
      chk("t2_gap1", valid_cyc[s0+1] - valid_cyc[s0], 10 * BIT);
      chk("t2_gap2", valid_cyc[s0+2] - valid_cyc[s0+1], 10 * BIT);
    end else chk("t2_gap_missing", 0, 1);

    // 3: short low glitch is rejected
    v0 = valid_cnt;
    f0 = fe_cnt;
    busy_seen = 1'b0;
    data_in = 1'b0;
    wait_cyc(5);
    data_in = 1'b1;
    wait_cyc(HALF + 3 - 5);
    chk("t3_busy_back", busy, 0);
    chk("t3_busy_seen", busy_seen, 1);
    wait_cyc(BIT);
    chk("t3_no_valid", valid_cnt - v0, 0);
    chk("t3_no_fe", fe_cnt - f0, 0);

    // 4: bad stop bit, line held low, then recovery
    v0 = valid_cnt;
    f0 = fe_cnt;
    r = last_good;
    send_byte(8'h5A, 1'b0);
    bad = 0;
    for (int i = 0; i < 3 * BIT; i++) begin
      if (byte_received !== r) bad++;
      @(negedge clk);
    end
    chk("t4_hold", bad, 0);
    chk("t4_fe", fe_cnt - f0, 1);
    chk("t4_busy_break", busy, 1);
    data_in = 1'b1;
    wait_cyc(BIT);
    chk("t4_idle", busy, 0);
    send_byte(8'h11, 1'b1);
    wait_cyc(2 * BIT);
    chk("t4_valid", valid_cnt - v0, 1);
    chk("t4_byte", byte_received, 8'h11);

    // 5: reset mid-frame discards the partial byte
    data_in = 1'b0;
    wait_cyc(BIT);
    r = 8'h77;
    for (int i = 0; i < 4; i++) begin
      data_in = r[i];
      wait_cyc(BIT);
    end
    reset = 1'b0;
    #1;
    chk("t5_rst_byte", byte_received, 8'h00);
    chk("t5_rst_valid", byte_valid, 0);
    chk("t5_rst_fe", framing_error, 0);
    chk("t5_rst_busy", busy, 0);
    data_in = 1'b1;
    wait_cyc(5);
    reset = 1'b1;
    last_good = 8'h00;
    wait_cyc(2 * BIT);
    v0 = valid_cnt;
    send_byte(8'h81, 1'b1);
    wait_cyc(2 * BIT);
    chk("t5_valid", valid_cnt - v0, 1);
    chk("t5_byte", byte_received, 8'h81);

    // 6: random back-to-back stream
    v0 = valid_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    wait_cyc(2 * BIT);
    chk("t6_count", valid_cnt - v0, 40);
    chk("t6_fe", fe_cnt - f0, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
